// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and the parity helper for the UART core.
package uart_pkg;

    // Oversampling ratio and the half-bit point used to find the start-bit centre
    localparam int OVERSAMPLE    = 16;
    localparam int HALF_BIT      = 8;
    // Widest supported data word; the parity helper works on this width
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Parity bit that makes XOR(data, parity) equal to 'odd'; narrower words are zero-extended
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: a down-counter reloaded from the runtime divisor.
// One os_tick pulse per expiry; a divisor of 0 gives a tick on every clock.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             os_tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick;

    // Tick on expiry and pick the reload value or the decremented count
    always_comb begin
        tick  = (cnt_q == '0);
        cnt_d = tick ? baud_div_i : (cnt_q - {{(DIV_W-1){1'b0}}, 1'b1});
    end

    // Counter register; the divisor is read only at reload time
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign os_tick_o = tick;

endmodule

// File: rtl/uart_core_cfg.sv
// Full-duplex UART with a shared 16x oversampling tick, runtime baud divisor and
// compile-time frame format. TX takes a valid/ready word; RX pulses a completed word
// together with its parity and framing status.
module uart_core_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam logic [3:0] SUB_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] HALF_LAST = 4'(HALF_BIT - 1);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);
    localparam logic       ODD       = (PARITY_ODD != 0);
    localparam logic       PAR_ON    = (PARITY_EN != 0);

    logic os_tick;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .baud_div_i(baud_div),
        .os_tick_o (os_tick)
    );

    // ---------------- TX ----------------
    tx_state_e              tx_state_q;
    logic                   tx_q;
    logic                   tx_ready_q;
    logic [3:0]             tx_sub_q;
    logic [3:0]             tx_bit_q;
    logic                   tx_stop_q;
    logic [DATA_BITS-1:0]   tx_shift_q;
    logic                   tx_par_q;
    logic [MAX_DATA_BITS-1:0] tx_ext;
    logic                   tx_par_d;

    // Parity of the word offered on tx_data, latched together with it at handshake
    always_comb begin
        tx_ext                  = '0;
        tx_ext[DATA_BITS-1:0]   = tx_data;
        tx_par_d                = parity_bit(tx_ext, ODD);
    end

    // TX FSM: every non-idle bit lasts exactly OVERSAMPLE ticks; line and ready are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_sub_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q       <= 1'b1;
                    tx_ready_q <= 1'b1;
                    if (tx_valid && tx_ready_q) begin
                        tx_shift_q <= tx_data;
                        tx_par_q   <= tx_par_d;
                        tx_sub_q   <= '0;
                        tx_q       <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                default: begin
                    if (os_tick) begin
                        if (tx_sub_q != SUB_LAST) begin
                            tx_sub_q <= tx_sub_q + 4'd1;
                        end else begin
                            tx_sub_q <= '0;
                            case (tx_state_q)
                                TX_START: begin
                                    tx_state_q <= TX_DATA;
                                    tx_bit_q   <= '0;
                                    tx_q       <= tx_shift_q[0];
                                    tx_shift_q <= tx_shift_q >> 1;
                                end
                                TX_DATA: begin
                                    if (tx_bit_q == BIT_LAST) begin
                                        if (PAR_ON) begin
                                            tx_state_q <= TX_PARITY;
                                            tx_q       <= tx_par_q;
                                        end else begin
                                            tx_state_q <= TX_STOP;
                                            tx_q       <= 1'b1;
                                            tx_stop_q  <= 1'b0;
                                        end
                                    end else begin
                                        tx_bit_q   <= tx_bit_q + 4'd1;
                                        tx_q       <= tx_shift_q[0];
                                        tx_shift_q <= tx_shift_q >> 1;
                                    end
                                end
                                TX_PARITY: begin
                                    tx_state_q <= TX_STOP;
                                    tx_q       <= 1'b1;
                                    tx_stop_q  <= 1'b0;
                                end
                                TX_STOP: begin
                                    if (tx_stop_q == STOP_LAST) begin
                                        // Back to IDLE with ready high; a waiting request handshakes next clock
                                        tx_state_q <= TX_IDLE;
                                        tx_ready_q <= 1'b1;
                                        tx_q       <= 1'b1;
                                    end else begin
                                        tx_stop_q <= 1'b1;
                                    end
                                end
                                default: begin
                                    tx_state_q <= TX_IDLE;
                                    tx_q       <= 1'b1;
                                    tx_ready_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- RX ----------------
    logic                     rx_meta_q;
    logic                     rx_sync_q;
    rx_state_e                rx_state_q;
    logic [3:0]               rx_sub_q;
    logic [3:0]               rx_bit_q;
    logic [DATA_BITS-1:0]     rx_shift_q;
    logic                     rx_par_q;
    logic [DATA_BITS-1:0]     rx_data_q;
    logic                     rx_valid_q;
    logic                     rx_parity_err_q;
    logic                     rx_frame_err_q;
    logic [MAX_DATA_BITS-1:0] rx_ext;
    logic                     rx_par_exp;

    // Two-flop synchroniser for the asynchronous serial input; idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Parity bit the received data word should have carried
    always_comb begin
        rx_ext                = '0;
        rx_ext[DATA_BITS-1:0] = rx_shift_q;
        rx_par_exp            = parity_bit(rx_ext, ODD);
    end

    // RX FSM: start detected on a low line in IDLE (IDLE is only entered with the line high,
    // so a low level there is a falling edge); samples taken at bit centres
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q      <= RX_IDLE;
            rx_sub_q        <= '0;
            rx_bit_q        <= '0;
            rx_shift_q      <= '0;
            rx_par_q        <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_sub_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (os_tick) begin
                        if (rx_sub_q != HALF_LAST) begin
                            rx_sub_q <= rx_sub_q + 4'd1;
                        end else begin
                            rx_sub_q <= '0;
                            if (rx_sync_q) begin
                                // Line back high at the start-bit centre: a glitch, not a frame
                                rx_state_q <= RX_IDLE;
                            end else begin
                                rx_bit_q   <= '0;
                                rx_state_q <= RX_DATA;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (os_tick) begin
                        if (rx_sub_q != SUB_LAST) begin
                            rx_sub_q <= rx_sub_q + 4'd1;
                        end else begin
                            rx_sub_q   <= '0;
                            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_bit_q == BIT_LAST) begin
                                rx_state_q <= PAR_ON ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + 4'd1;
                            end
                        end
                    end
                end
                RX_PARITY: begin
                    if (os_tick) begin
                        if (rx_sub_q != SUB_LAST) begin
                            rx_sub_q <= rx_sub_q + 4'd1;
                        end else begin
                            rx_sub_q   <= '0;
                            rx_par_q   <= rx_sync_q;
                            rx_state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (os_tick) begin
                        if (rx_sub_q != SUB_LAST) begin
                            rx_sub_q <= rx_sub_q + 4'd1;
                        end else begin
                            rx_sub_q        <= '0;
                            rx_data_q       <= rx_shift_q;
                            rx_valid_q      <= 1'b1;
                            rx_parity_err_q <= PAR_ON && (rx_par_q != rx_par_exp);
                            rx_frame_err_q  <= !rx_sync_q;
                            // A low stop bit may be a break; hold off until the line recovers
                            rx_state_q      <= rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign tx            = tx_q;
    assign tx_ready      = tx_ready_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_frame_err  = rx_frame_err_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Bench for uart_core_cfg: 8 data bits, even parity, 1 stop bit.
module tb_uart_core_cfg;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   baud_div = '0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          rx_line;
    logic          rx_drv = 1'b1;
    logic          loop_en = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_parity_err;
    logic          rx_frame_err;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_core_cfg #(
        .DATA_BITS (8),
        .PARITY_EN (1),
        .PARITY_ODD(0),
        .STOP_BITS (1),
        .DIV_W     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_div     (baud_div),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx           (tx),
        .rx           (rx_line),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;

    exp_t    sb_q[$];
    rx_vec_t vecs[6];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      rx_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: every rx_valid pulse pops and compares one expected word
    always @(negedge clk) begin
        if (rst_n && rx_valid === 1'b1) begin
            rx_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_valid: got rx_data %0h with no frame outstanding", rx_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
                check("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
            end
        end
    end

    // One bit time at baud_div=0 is 16 clocks
    task automatic drive_bits(input logic v, input int nbits);
        rx_drv = v;
        repeat (nbits * 16) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
        drive_bits(par, 1);
        drive_bits(stop, 1);
        drive_bits(1'b1, 2);
    endtask

    task automatic wait_tx_ready(input int limit);
        int n = 0;
        while (tx_ready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_ready_timeout: got tx_ready %b, expected 1 within %0d clks", tx_ready, limit);
        end
    endtask

    // Count consecutive negedge samples of tx equal to v (bounded)
    task automatic run_length(input logic v, input int limit, output int n);
        n = 0;
        while (tx === v && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_tx_level(input logic v, input int limit, input string name);
        int n = 0;
        while (tx !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got tx %b, expected %b within %0d clks", name, tx, v, limit);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        // Parity column is the transmitted bit; even parity of each word is noted alongside
        vecs[0] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};  // correct parity 1
        vecs[1] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0};  // correct parity 0
        vecs[2] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};  // correct parity 1
        vecs[3] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};  // stop low for one bit
        vecs[4] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b1};  // both errors
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};  // correct parity 0

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_parity_err", 32'(rx_parity_err), 32'd0);
        check("reset_rx_frame_err", 32'(rx_frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Loopback 0xA5
        base = rx_cnt;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        push_exp(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_start_after_handshake", 32'(tx), 32'd0);
        check("tx_ready_drops", 32'(tx_ready), 32'd0);
        n = 0;
        while (tx_ready === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("tx_ready_low_clks", 32'(n), 32'(16 * (1 + 8 + 1 + 1)));
        repeat (40) @(negedge clk);
        check("loopback_a5_frames", 32'(rx_cnt - base), 32'd1);

        // Back-to-back 0x00 then 0xFF with tx_valid held
        base = rx_cnt;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        push_exp(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        tx_data = 8'hFF;
        push_exp(8'hFF, 1'b0, 1'b0);
        wait_tx_level(1'b1, 400, "b2b_stop_timeout");
        run_length(1'b1, 400, n);
        tx_valid = 1'b0;
        // 16 stop-bit clocks plus the one IDLE clock in which the held request handshakes
        check("b2b_stop_high_clks", 32'(n), 32'd17);
        wait_tx_ready(400);
        repeat (40) @(negedge clk);
        check("b2b_frames", 32'(rx_cnt - base), 32'd2);

        // Table-driven frames on the rx pin
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (32) @(negedge clk);
        base = rx_cnt;
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
            drive_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
        end
        check("table_frames", 32'(rx_cnt - base), 32'd6);

        // Break: 0x3C with the stop bit low and the line held low for 40 bit times
        base = rx_cnt;
        push_exp(8'h3C, 1'b0, 1'b1);
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(8'h3C >> i, 1);
        drive_bits(1'b0, 1);
        drive_bits(1'b0, 40);
        check("break_frames_while_low", 32'(rx_cnt - base), 32'd1);
        drive_bits(1'b1, 2);
        push_exp(8'h99, 1'b0, 1'b0);
        drive_frame(8'h99, 1'b0, 1'b1);
        check("after_break_frames", 32'(rx_cnt - base), 32'd2);

        // Glitch: 4 ticks low then high
        base = rx_cnt;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
        check("glitch_no_frame", 32'(rx_cnt - base), 32'd0);
        push_exp(8'h42, 1'b0, 1'b0);
        drive_frame(8'h42, 1'b0, 1'b1);
        check("after_glitch_frames", 32'(rx_cnt - base), 32'd1);

        // baud_div=5, 0x5A in loopback, reset during data bits
        baud_div = 16'd5;
        loop_en  = 1'b1;
        repeat (20) @(negedge clk);
        base = rx_cnt;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        // Data 0x5A LSB first: 0,1,0,1,1,... -> bit1 high alone, bit2 low alone
        wait_tx_level(1'b1, 2000, "div5_bit1_timeout");
        run_length(1'b1, 500, n);
        check("div5_bit1_clks", 32'(n), 32'd96);
        run_length(1'b0, 500, n);
        check("div5_bit2_clks", 32'(n), 32'd96);
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_tx", 32'(tx), 32'd1);
        check("midframe_reset_tx_ready", 32'(tx_ready), 32'd1);
        check("midframe_reset_rx_data", 32'(rx_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1500) @(negedge clk);
        check("midframe_reset_no_rx", 32'(rx_cnt - base), 32'd0);
        check("post_reset_tx_idle", 32'(tx), 32'd1);
        check("post_reset_tx_ready", 32'(tx_ready), 32'd1);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
